// File: rtl/compressor_error_monitor_if.sv
// Port bundle between the compressor characterisation engine (master) and the
// compressor-under-test / controlling environment (slave).
interface compressor_error_monitor_if;
  logic       start;
  logic [3:0] stim;
  logic       stim_valid;
  logic       S_in;
  logic       C_in;
  logic       busy;
  logic       done;
  logic [4:0] err_cnt;
  logic [6:0] abs_err_sum;
  logic [6:0] signed_err_sum;
  logic [2:0] max_abs_err;
  logic [3:0] first_err_vec;

  modport master (
    input  start, S_in, C_in,
    output stim, stim_valid, busy, done,
           err_cnt, abs_err_sum, signed_err_sum, max_abs_err, first_err_vec
  );

  modport slave (
    output start, S_in, C_in,
    input  stim, stim_valid, busy, done,
           err_cnt, abs_err_sum, signed_err_sum, max_abs_err, first_err_vec
  );
endinterface

// File: rtl/compressor_error_monitor.sv
// Drives all 16 vectors into a 4:2 compressor, scores {C,S} against the exact
// popcount after a LAT-cycle delay and accumulates error statistics.
module compressor_error_monitor #(
  parameter int unsigned LAT = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  compressor_error_monitor_if.master        bus
);

  // state | meaning
  // IDLE  | waiting for start; results hold
  // RUN   | issuing vectors 0..15, one per cycle
  // DRAIN | LAT cycles waiting for the last responses
  // DONE  | one-cycle done pulse, then back to IDLE
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [2:0] DRAIN_LOAD = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

  state_t     r_state;
  logic [3:0] r_stim;
  logic       r_stim_valid;
  logic       r_busy;
  logic       r_done;
  logic [2:0] r_drain_cnt;

  logic [4:0] r_err_cnt;
  logic [6:0] r_abs_sum;
  logic [6:0] r_sgn_sum;
  logic [2:0] r_max_abs;
  logic [3:0] r_first_vec;

  logic       w_run_start;
  logic       w_dly_valid;
  logic [3:0] w_dly_vec;
  logic [2:0] w_exact;
  logic [2:0] w_approx;
  logic signed [3:0] w_diff;
  logic [2:0] w_abs;
  logic       w_score;

  assign w_run_start = (r_state == S_IDLE) && bus.start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_stim       <= 4'd0;
      r_stim_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_drain_cnt  <= 3'd0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state      <= S_RUN;
            r_stim       <= 4'd0;
            r_stim_valid <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        S_RUN: begin
          // r_stim doubles as the vector index while issuing
          if (r_stim == 4'd15) begin
            r_stim       <= 4'd0;
            r_stim_valid <= 1'b0;
            if (LAT > 0) begin
              r_state     <= S_DRAIN;
              r_drain_cnt <= DRAIN_LOAD;
            end else begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_stim <= r_stim + 4'd1;
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == 3'd0) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt - 3'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The delay line mirrors the compressor latency so each response meets its vector
  if (LAT == 0) begin : g_no_delay
    assign w_dly_valid = r_stim_valid;
    assign w_dly_vec   = r_stim;
  end else begin : g_delay
    logic [LAT-1:0] r_vld_pipe;
    logic [3:0]     r_vec_pipe [LAT];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_vld_pipe <= '0;
        for (int i = 0; i < LAT; i++) begin
          r_vec_pipe[i] <= 4'd0;
        end
      end else begin
        r_vld_pipe[0] <= r_stim_valid;
        r_vec_pipe[0] <= r_stim;
        for (int i = 1; i < LAT; i++) begin
          r_vld_pipe[i] <= r_vld_pipe[i-1];
          r_vec_pipe[i] <= r_vec_pipe[i-1];
        end
      end
    end

    assign w_dly_valid = r_vld_pipe[LAT-1];
    assign w_dly_vec   = r_vec_pipe[LAT-1];
  end

  always_comb begin
    w_exact  = 3'(w_dly_vec[0]) + 3'(w_dly_vec[1]) + 3'(w_dly_vec[2]) + 3'(w_dly_vec[3]);
    w_approx = {1'b0, bus.C_in, bus.S_in};
    w_diff   = signed'({1'b0, w_approx}) - signed'({1'b0, w_exact});
    w_abs    = w_diff[3] ? 3'(-w_diff) : w_diff[2:0];
    w_score  = w_dly_valid && (w_diff != 4'sd0);
  end

  // Scoring never overlaps an accepted start: the pipeline is empty in IDLE
  always_ff @(posedge clk) begin
    if (!rst_n || w_run_start) begin
      r_err_cnt   <= 5'd0;
      r_abs_sum   <= 7'd0;
      r_sgn_sum   <= 7'd0;
      r_max_abs   <= 3'd0;
      r_first_vec <= 4'd0;
    end else if (w_score) begin
      r_err_cnt <= r_err_cnt + 5'd1;
      r_abs_sum <= r_abs_sum + {4'd0, w_abs};
      r_sgn_sum <= r_sgn_sum + {{3{w_diff[3]}}, w_diff};
      if (w_abs > r_max_abs) begin
        r_max_abs <= w_abs;
      end
      if (r_err_cnt == 5'd0) begin
        r_first_vec <= w_dly_vec;
      end
    end
  end

  assign bus.stim           = r_stim;
  assign bus.stim_valid     = r_stim_valid;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.err_cnt        = r_err_cnt;
  assign bus.abs_err_sum    = r_abs_sum;
  assign bus.signed_err_sum = r_sgn_sum;
  assign bus.max_abs_err    = r_max_abs;
  assign bus.first_err_vec  = r_first_vec;

endmodule

// File: tb/tb_compressor_error_monitor.sv
// Bench for compressor_error_monitor: LAT=0 and LAT=3 instances driven by
// behavioural compressor models, checked against a popcount reference.
module tb_compressor_error_monitor;

  typedef logic [1:0] lut_t [16];
  typedef struct { int err; int abs_s; int sgn; int mx; int first; } res_t;
  typedef struct { int d; int mode; int poke; res_t exp; } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  compressor_error_monitor_if b0();
  compressor_error_monitor_if b1();

  compressor_error_monitor #(.LAT(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  compressor_error_monitor #(.LAT(3)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  logic [1:0] st = 2'b00;
  assign b0.start = st[0];
  assign b1.start = st[1];

  logic [1:0] w_done, w_busy, w_sv;
  logic [3:0] w_stim [2];
  logic [4:0] w_err [2];
  logic [6:0] w_abs [2];
  logic [6:0] w_sgn [2];
  logic [2:0] w_mx [2];
  logic [3:0] w_first [2];

  assign w_done = {b1.done, b0.done};
  assign w_busy = {b1.busy, b0.busy};
  assign w_sv   = {b1.stim_valid, b0.stim_valid};
  assign w_stim[0] = b0.stim;            assign w_stim[1] = b1.stim;
  assign w_err[0] = b0.err_cnt;          assign w_err[1] = b1.err_cnt;
  assign w_abs[0] = b0.abs_err_sum;      assign w_abs[1] = b1.abs_err_sum;
  assign w_sgn[0] = b0.signed_err_sum;   assign w_sgn[1] = b1.signed_err_sum;
  assign w_mx[0] = b0.max_abs_err;       assign w_mx[1] = b1.max_abs_err;
  assign w_first[0] = b0.first_err_vec;  assign w_first[1] = b1.first_err_vec;

  // Compressor models: response table per DUT; random junk when no vector is live
  lut_t resp0;
  lut_t resp1;
  logic [1:0] junk = 2'd0;
  always @(negedge clk) junk <= 2'($urandom);

  logic [2:0] hv = 3'd0;
  logic [3:0] hs [3] = '{default: 4'd0};
  always @(posedge clk) begin
    hv    <= {hv[1:0], b1.stim_valid};
    hs[0] <= b1.stim;
    hs[1] <= hs[0];
    hs[2] <= hs[1];
  end

  assign {b0.C_in, b0.S_in} = b0.stim_valid ? resp0[b0.stim] : junk;
  assign {b1.C_in, b1.S_in} = hv[2] ? resp1[hs[2]] : junk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // mode 0 golden high-speed compressor, 1 exact clipped, 2 stuck-at-zero, else random
  function automatic lut_t make_lut(input int mode);
    lut_t t;
    logic [3:0] v;
    int cnt;
    for (int n = 0; n < 16; n++) begin
      v = 4'(n);
      cnt = $countones(v);
      case (mode)
        0: t[n] = {v[2] | v[3], ((v[2] ^ v[3]) & v[0] & v[1]) | (~(v[2] ^ v[3]) & (v[0] | v[1]))};
        1: t[n] = (cnt > 3) ? 2'd3 : 2'(cnt);
        2: t[n] = 2'd0;
        default: t[n] = 2'($urandom);
      endcase
    end
    return t;
  endfunction

  function automatic res_t score(input lut_t t);
    res_t r;
    int diff;
    int a;
    r = '{0, 0, 0, 0, 0};
    for (int n = 0; n < 16; n++) begin
      diff = int'(t[n]) - $countones(4'(n));
      a = (diff < 0) ? -diff : diff;
      if (diff != 0) begin
        if (r.err == 0) r.first = n;
        r.err++;
        r.abs_s += a;
        r.sgn += diff;
        if (a > r.mx) r.mx = a;
      end
    end
    return r;
  endfunction

  task automatic set_lut(input int d, input lut_t t);
    if (d == 0) resp0 = t;
    else        resp1 = t;
  endtask

  task automatic check_res(input int d, input string nm, input res_t e);
    chk({nm, " err_cnt"},        int'(w_err[d]), e.err);
    chk({nm, " abs_err_sum"},    int'(w_abs[d]), e.abs_s);
    chk({nm, " signed_err_sum"}, int'($signed(w_sgn[d])), e.sgn);
    chk({nm, " max_abs_err"},    int'(w_mx[d]), e.mx);
    chk({nm, " first_err_vec"},  int'(w_first[d]), e.first);
  endtask

  // Pulses start, follows the issue sequence to done; poke>0 re-pulses start in that cycle
  task automatic do_run(input int d, input string nm, input int poke, input res_t e);
    int lat;
    int c;
    bit seq_ok;
    lat = (d == 0) ? 0 : 3;
    @(negedge clk); st[d] = 1'b1;
    @(negedge clk); st[d] = 1'b0;
    c = 1;
    seq_ok = 1'b1;
    while (!w_done[d] && c < 64) begin
      if (c <= 16) begin
        if (!w_sv[d] || w_stim[d] != 4'(c - 1) || !w_busy[d]) seq_ok = 1'b0;
      end else if (w_sv[d] || w_stim[d] != 4'd0 || !w_busy[d]) begin
        seq_ok = 1'b0;
      end
      st[d] = (c == poke);
      @(negedge clk);
      c++;
    end
    st[d] = 1'b0;
    chk({nm, " issue sequence"}, int'(seq_ok), 1);
    chk({nm, " done latency"}, c, 17 + lat);
    chk({nm, " busy at done"}, int'(w_busy[d]), 0);
    check_res(d, nm, e);
    @(negedge clk);
    chk({nm, " done one cycle"}, int'(w_done[d]), 0);
    check_res(d, {nm, " hold"}, e);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [8];
    res_t golden;
    res_t stuck;
    res_t e;
    int c;
    int d;

    golden = '{4, 4, 0, 1, 3};
    stuck  = '{15, 32, -32, 4, 1};
    tbl[0] = '{0, 0, 0,  golden};
    tbl[1] = '{1, 1, 0,  '{1, 1, -1, 1, 15}};
    tbl[2] = '{0, 2, 0,  stuck};
    tbl[3] = '{1, 2, 0,  stuck};
    tbl[4] = '{1, 0, 0,  golden};
    tbl[5] = '{0, 1, 0,  '{1, 1, -1, 1, 15}};
    tbl[6] = '{0, 0, 5,  golden};
    tbl[7] = '{1, 0, 18, golden};

    resp0 = make_lut(2);
    resp1 = make_lut(2);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset busy", int'(w_busy[i]), 0);
      chk("reset done", int'(w_done[i]), 0);
      chk("reset stim_valid", int'(w_sv[i]), 0);
      chk("reset stim", int'(w_stim[i]), 0);
      check_res(i, "reset", '{0, 0, 0, 0, 0});
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      set_lut(tbl[i].d, make_lut(tbl[i].mode));
      do_run(tbl[i].d, $sformatf("vec%0d", i), tbl[i].poke, tbl[i].exp);
    end

    // Reset in the middle of a run at vector 9
    resp0 = make_lut(0);
    @(negedge clk); st[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0;
    c = 0;
    while (!(w_sv[0] && w_stim[0] == 4'd9) && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk("midrst reached vector", int'(w_stim[0]), 9);
    chk("midrst err_cnt before reset", int'(w_err[0]), 3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst busy", int'(w_busy[0]), 0);
    chk("midrst stim_valid", int'(w_sv[0]), 0);
    chk("midrst stim", int'(w_stim[0]), 0);
    chk("midrst done", int'(w_done[0]), 0);
    check_res(0, "midrst", '{0, 0, 0, 0, 0});
    repeat (3) @(negedge clk);
    chk("midrst stays idle", int'(w_busy[0]) + int'(w_sv[0]), 0);
    do_run(0, "after reset", 0, golden);

    // start held high: stuck-at-zero run, then golden run re-triggered automatically
    resp0 = make_lut(2);
    @(negedge clk); st[0] = 1'b1;
    c = 0;
    while (!w_done[0] && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk("held first done seen", int'(w_done[0]), 1);
    check_res(0, "held run1", stuck);
    @(negedge clk);
    resp0 = make_lut(0);
    c = 1;
    while (!w_done[0] && c < 40) begin
      @(negedge clk);
      c++;
      if (c == 2) chk("held start clears err_cnt", int'(w_err[0]), 0);
    end
    st[0] = 1'b0;
    chk("held done spacing", c, 18);
    check_res(0, "held run2", golden);
    repeat (3) @(negedge clk);
    chk("held release idle", int'(w_busy[0]), 0);

    // Randomized compressor behaviour against the popcount reference
    for (int i = 0; i < 8; i++) begin
      lut_t t;
      d = i % 2;
      t = make_lut(3);
      e = score(t);
      set_lut(d, t);
      do_run(d, $sformatf("rand%0d", i), 0, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
